fifo: RTL and testbench
=======================

# fifo

Synchronous single-clock FIFO buffering 8-bit data words between a producer and a consumer in the same clock domain. The producer pushes words with a write strobe, and the consumer pops them in arrival order with a read strobe. The block reports empty, full and current occupancy, so both sides can throttle without external bookkeeping.

## Interface
- DATA_WIDTH, 8, width of each stored word
- DEPTH, 8, number of storage entries (power of two)
- CNT_WIDTH, 4, width of occupancy count; equals log2(DEPTH)+1 so the value DEPTH is representable
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-low (0 = reset asserted)
- wr  input  1  write request; pushes data_in on a rising edge when not full
- data_in  input  DATA_WIDTH  word to push
- rd  input  1  read request; pops head word into data_out on a rising edge when not empty
- data_out  output  DATA_WIDTH  registered output holding the most recently popped word
- empty  output  1  high when occupancy is 0
- full  output  1  high when occupancy equals DEPTH
- fifo_cnt  output  CNT_WIDTH  current occupancy, 0..DEPTH

## Operation
- Storage is an array of DEPTH words with a write pointer and a read pointer, each log2(DEPTH) bits wide. Both pointers wrap modulo DEPTH.
- Write is accepted when wr=1 and full=0:
  - mem[wr_ptr] <= data_in
  - wr_ptr increments
- Write while full is ignored: memory, pointer and count are unchanged, and no error is raised unless FIFO_ERR_FLAGS_EN is defined.
- Read is accepted when rd=1 and empty=0:
  - data_out <= mem[rd_ptr]
  - rd_ptr increments
- Read while empty is ignored and data_out holds its value.
- Simultaneous wr=1 and rd=1:
  - Neither full nor empty: both accepted, fifo_cnt unchanged.
  - Empty: only the write is accepted, fifo_cnt becomes 1, data_out unchanged.
  - Full: only the read is accepted, fifo_cnt becomes DEPTH-1.
- fifo_cnt increments on an accepted write alone, decrements on an accepted read alone, and is otherwise held.
- empty = (fifo_cnt==0); full = (fifo_cnt==DEPTH). Both are derived combinationally from the count register.
- No write-to-read bypass: a word becomes readable on the cycle after it is written.

## Timing
- Reset (rst=0) is asynchronous:
  - Pointers and fifo_cnt become 0 immediately.
  - data_out becomes 0.
  - empty=1, full=0.
  - Memory contents are not cleared.
- Reset asserted mid-operation discards all stored data.
- The first accepted write may occur on the first rising edge after rst returns to 1.
- Write latency: occupancy and flags update on the same edge that accepts the write.
- Read latency: data_out is valid after the accepting edge, one cycle after rd is sampled high, and holds until the next accepted read.

## Configuration
- Macro FIFO_ERR_FLAGS_EN.
- When defined, two extra 1-bit outputs are added:
  - overflow: set on an edge where wr=1 and full=1.
  - underflow: set on an edge where rd=1 and empty=1, with no simultaneous accepted write, so the empty-with-wr case does not set it.
- Both flags are sticky until reset and reset to 0.
- When the macro is undefined, these ports and their logic are absent, and ignored requests are silent.

## Test plan
- Reset: drive rst=0 for 2 cycles -> empty=1, full=0, fifo_cnt=0, data_out=0.
- Ordered transfer:
  - Release reset, write 0x01, 0x02, 0x03, 0x04 on consecutive edges -> fifo_cnt 1,2,3,4, empty=0.
  - Then rd=1 for 4 edges -> data_out 0x01, 0x02, 0x03, 0x04, fifo_cnt down to 0, empty=1.
  - Further rd leaves data_out at 0x04.
- Fill to full: 9 consecutive writes of 0x10..0x18 -> full=1, fifo_cnt=8 after the 8th write. 0x18 is dropped; 8 reads return 0x10..0x17.
- Wrap-around: write 6, read 6, write 8, read 8 -> all data returned in order, with pointers wrapping past index 7.
- Simultaneous events:
  - With 3 entries, wr=1 and rd=1 for 4 edges -> fifo_cnt stays 3 and data_out follows FIFO order.
  - When empty, wr=1 and rd=1 -> fifo_cnt=1 and data_out unchanged.
- Async reset mid-stream: pull rst low between edges while fifo_cnt=5 -> outputs return to reset values before the next edge. With FIFO_ERR_FLAGS_EN defined, overflow and underflow also clear.

Source files
------------

// File: rtl/fifo.sv
// Synchronous single-clock FIFO with registered read data and occupancy count.
// Optional sticky overflow/underflow outputs are enabled by defining FIFO_ERR_FLAGS_EN.
module fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [CNT_WIDTH-1:0]  fifo_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  wr_en, rd_en;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_WIDTH'(DEPTH));
  assign fifo_cnt = cnt_q;
  assign data_out = data_out_q;

  // Requests against a full/empty FIFO are dropped here; the simultaneous
  // cases fall out of these gates without extra logic.
  assign wr_en = wr & ~full;
  assign rd_en = rd & ~empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + PtrW'(1);
      data_out_d = mem_q[rd_ptr_q];
    end
    unique case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
      2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (wr & full);
    // A write into an empty FIFO makes the paired read legal-but-ignored, not an underflow.
    underflow_d = underflow_q | (rd & empty & ~wr_en);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo; also checks the error flags when
// FIFO_ERR_FLAGS_EN is defined.
module tb_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic [7:0] data_in;
  logic       rd;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
  logic [3:0] fifo_cnt;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  int errors = 0;
  int checks = 0;

  fifo #(
    .DATA_WIDTH(8),
    .DEPTH     (8),
    .CNT_WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .data_in  (data_in),
    .rd       (rd),
    .data_out (data_out),
    .empty    (empty),
    .full     (full),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow (overflow),
    .underflow(underflow),
`endif
    .fifo_cnt (fifo_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr = 1'b0; rd = 1'b0; data_in = 8'h00;
    tick(); tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", fifo_cnt); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", data_out); end
`ifdef FIFO_ERR_FLAGS_EN
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL reset_flags got=%b%b exp=00", overflow, underflow);
    end
`endif
    rst = 1'b1;
  endtask

  task automatic test_ordered();
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; data_in = 8'(i + 1);
      tick();
      checks++; if (fifo_cnt !== 4'(i + 1)) begin errors++; $display("FAIL ord_wr_cnt%0d got=%0d exp=%0d", i, fifo_cnt, i + 1); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL ord_wr_empty%0d got=%b exp=0", i, empty); end
    end
    wr = 1'b0; rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (data_out !== 8'(i + 1)) begin errors++; $display("FAIL ord_rd_data%0d got=%h exp=%h", i, data_out, 8'(i + 1)); end
      checks++; if (fifo_cnt !== 4'(3 - i)) begin errors++; $display("FAIL ord_rd_cnt%0d got=%0d exp=%0d", i, fifo_cnt, 3 - i); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ord_empty got=%b exp=1", empty); end
    tick();
    checks++; if (data_out !== 8'h04) begin errors++; $display("FAIL ord_underrun_data got=%h exp=04", data_out); end
    checks++; if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL ord_underrun_cnt got=%0d exp=0", fifo_cnt); end
`ifdef FIFO_ERR_FLAGS_EN
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set got=%b exp=1", underflow); end
`endif
    rd = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 9; i++) begin
      wr = 1'b1; data_in = 8'(8'h10 + i);
      tick();
      checks++; if (fifo_cnt !== 4'((i < 8) ? i + 1 : 8)) begin
        errors++; $display("FAIL fill_cnt%0d got=%0d exp=%0d", i, fifo_cnt, (i < 8) ? i + 1 : 8);
      end
      checks++; if (full !== (i >= 7)) begin errors++; $display("FAIL fill_full%0d got=%b exp=%b", i, full, i >= 7); end
    end
`ifdef FIFO_ERR_FLAGS_EN
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got=%b exp=1", overflow); end
`endif
    wr = 1'b0; rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (data_out !== 8'(8'h10 + i)) begin errors++; $display("FAIL fill_rd%0d got=%h exp=%h", i, data_out, 8'(8'h10 + i)); end
    end
    checks++; if (empty !== 1'b1 || fifo_cnt !== 4'd0) begin
      errors++; $display("FAIL fill_drained got=empty%b cnt%0d exp=empty1 cnt0", empty, fifo_cnt);
    end
    rd = 1'b0;
  endtask

  task automatic test_wrap();
    rd = 1'b0; wr = 1'b1;
    for (int i = 0; i < 6; i++) begin data_in = 8'(8'h20 + i); tick(); end
    wr = 1'b0; rd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (data_out !== 8'(8'h20 + i)) begin errors++; $display("FAIL wrap6_rd%0d got=%h exp=%h", i, data_out, 8'(8'h20 + i)); end
    end
    rd = 1'b0; wr = 1'b1;
    for (int i = 0; i < 8; i++) begin data_in = 8'(8'h30 + i); tick(); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL wrap8_full got=%b exp=1", full); end
    wr = 1'b0; rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (data_out !== 8'(8'h30 + i)) begin errors++; $display("FAIL wrap8_rd%0d got=%h exp=%h", i, data_out, 8'(8'h30 + i)); end
    end
    rd = 1'b0;
  endtask

  task automatic test_simultaneous();
    wr = 1'b1;
    for (int i = 0; i < 3; i++) begin data_in = 8'(8'h41 + i); tick(); end
    rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 8'(8'h44 + i);
      tick();
      checks++; if (fifo_cnt !== 4'd3) begin errors++; $display("FAIL sim_cnt%0d got=%0d exp=3", i, fifo_cnt); end
      checks++; if (data_out !== 8'(8'h41 + i)) begin errors++; $display("FAIL sim_data%0d got=%h exp=%h", i, data_out, 8'(8'h41 + i)); end
    end
    wr = 1'b0;
    tick(); tick(); tick();
    checks++; if (data_out !== 8'h47 || empty !== 1'b1) begin
      errors++; $display("FAIL sim_drain got=%h empty%b exp=47 empty1", data_out, empty);
    end
    // Both strobes into an empty FIFO: only the write lands.
    wr = 1'b1; data_in = 8'h50;
    tick();
    checks++; if (fifo_cnt !== 4'd1) begin errors++; $display("FAIL sim_empty_cnt got=%0d exp=1", fifo_cnt); end
    checks++; if (data_out !== 8'h47) begin errors++; $display("FAIL sim_empty_data got=%h exp=47", data_out); end
    rd = 1'b0;
    for (int i = 0; i < 7; i++) begin data_in = 8'(8'h51 + i); tick(); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL sim_fill got=%b exp=1", full); end
    // Both strobes into a full FIFO: only the read lands.
    rd = 1'b1; data_in = 8'hee;
    tick();
    checks++; if (fifo_cnt !== 4'd7) begin errors++; $display("FAIL sim_full_cnt got=%0d exp=7", fifo_cnt); end
    checks++; if (data_out !== 8'h50) begin errors++; $display("FAIL sim_full_data got=%h exp=50", data_out); end
    wr = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++; if (data_out !== 8'h57) begin errors++; $display("FAIL sim_full_last got=%h exp=57", data_out); end
    rd = 1'b0;
  endtask

  task automatic test_async_reset();
    wr = 1'b1;
    for (int i = 0; i < 6; i++) begin data_in = 8'(8'h60 + i); tick(); end
    wr = 1'b0; rd = 1'b1;
    tick();
    rd = 1'b0;
    checks++; if (fifo_cnt !== 4'd5 || data_out !== 8'h60) begin
      errors++; $display("FAIL arst_pre got=cnt%0d data%h exp=cnt5 data60", fifo_cnt, data_out);
    end
    rst = 1'b0;
    #2;
    checks++; if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL arst_cnt got=%0d exp=0", fifo_cnt); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL arst_flags got=e%b f%b exp=e1 f0", empty, full); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL arst_data got=%h exp=00", data_out); end
`ifdef FIFO_ERR_FLAGS_EN
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL arst_err got=%b%b exp=00", overflow, underflow);
    end
`endif
    tick();
    rst = 1'b1;
    // Stored data was discarded: a fresh write/read returns only the new word.
    wr = 1'b1; data_in = 8'h77;
    tick();
    wr = 1'b0; rd = 1'b1;
    tick();
    rd = 1'b0;
    checks++; if (data_out !== 8'h77 || empty !== 1'b1) begin
      errors++; $display("FAIL arst_after got=%h empty%b exp=77 empty1", data_out, empty);
    end
  endtask

  initial begin
    test_reset();
    test_ordered();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
